// File: rtl/stall_timer.sv
// stall_timer: multi-channel programmable PC-stall timer.
// Each channel turns a rising edge on its request line into a stall of a
// programmed number of cycles; pcEn is low while any channel is stalling.
// A saturating statistic counts the cycles in which pcEn was low.
module stall_timer #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned WIDTH  = 13,
   parameter int unsigned STAT_W = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CH-1:0]         delayEn,
   input  logic [NUM_CH*WIDTH-1:0]   delayLen,
   input  logic [NUM_CH-1:0]         retrig,
   output logic                      pcEn,
   output logic [NUM_CH-1:0]         busy,
   output logic [NUM_CH-1:0]         done,
   output logic [STAT_W-1:0]         stallCycles
);

   logic [NUM_CH-1:0] prevQ;
   logic [NUM_CH-1:0] rise;
   logic [WIDTH-1:0]  cntQ [NUM_CH];
   logic [WIDTH-1:0]  cntD [NUM_CH];
   logic [NUM_CH-1:0] doneQ;
   logic [NUM_CH-1:0] doneD;
   logic [STAT_W-1:0] statQ;
   logic [STAT_W-1:0] statD;

   assign rise = delayEn & ~prevQ;

   // Per-channel counter next state: load on an accepted edge, else count down.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cntD[i]  = cntQ[i];
         doneD[i] = 1'b0;
         if (rise[i] && ((cntQ[i] == '0) || retrig[i])) begin
            // A reload never reports expiry, even when it cancels (length 0).
            cntD[i] = delayLen[i*WIDTH +: WIDTH];
         end else if (cntQ[i] != '0) begin
            // A discarded edge (retrig = 0 while busy) lands here too.
            cntD[i]  = cntQ[i] - WIDTH'(1);
            doneD[i] = (cntQ[i] == WIDTH'(1));
         end
      end
   end

   // Busy flags and PC enable come straight from the counter registers.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         busy[i] = (cntQ[i] != '0);
      end
      pcEn = ~|busy;
   end

   // Stall statistic: count stalled cycles, hold at all-ones.
   always_comb begin
      statD = statQ;
      if (!pcEn && !(&statQ)) begin
         statD = statQ + STAT_W'(1);
      end
   end

   // State registers with synchronous reset taking priority over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         prevQ <= '0;
         doneQ <= '0;
         statQ <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            cntQ[i] <= '0;
         end
      end else begin
         prevQ <= delayEn;
         doneQ <= doneD;
         statQ <= statD;
         for (int i = 0; i < NUM_CH; i++) begin
            cntQ[i] <= cntD[i];
         end
      end
   end

   assign done        = doneQ;
   assign stallCycles = statQ;

endmodule

// File: tb/tb_stall_timer.sv
// Testbench for stall_timer: directed scenarios plus randomized traffic,
// checked against a time-based reference model (stall end times per channel).
module tb_stall_timer;

   logic        clk;
   logic        rst;
   logic [1:0]  delayEn;
   logic [25:0] delayLen;
   logic [1:0]  retrig;
   logic        pcEn;
   logic [1:0]  busy;
   logic [1:0]  done;
   logic [15:0] stallCycles;
   logic        sPcEn;
   logic [1:0]  sBusy;
   logic [1:0]  sDone;
   logic [3:0]  sStall;

   int checks = 0;
   int errors = 0;

   stall_timer #(.NUM_CH(2), .WIDTH(13), .STAT_W(16)) dut (
      .clk(clk), .rst(rst), .delayEn(delayEn), .delayLen(delayLen), .retrig(retrig),
      .pcEn(pcEn), .busy(busy), .done(done), .stallCycles(stallCycles)
   );

   stall_timer #(.NUM_CH(2), .WIDTH(13), .STAT_W(4)) dutSat (
      .clk(clk), .rst(rst), .delayEn(delayEn), .delayLen(delayLen), .retrig(retrig),
      .pcEn(sPcEn), .busy(sBusy), .done(sDone), .stallCycles(sStall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a stall is a time interval [start, mEnd) in edge numbers.
   int       now = 0;
   bit       mActive [2];
   int       mEnd [2];
   bit [1:0] mPrev = '0;
   bit [1:0] mDone = '0;
   int       mStat = 0;
   int       mStatS = 0;

   logic [29:0] obs;
   assign obs = {pcEn, busy, done, stallCycles, sPcEn, sBusy, sDone, sStall};

   function automatic logic [29:0] expVec();
      logic [1:0] b;
      for (int i = 0; i < 2; i++) b[i] = mActive[i] && (now < mEnd[i]);
      return {~|b, b, mDone, mStat[15:0], ~|b, b, mDone, mStatS[3:0]};
   endfunction

   // Advance one clock edge, update the model from the sampled inputs, settle.
   task automatic tick();
      bit [1:0] bb;
      bit       rs;
      bit       nat;
      int       len;
      @(posedge clk);
      now++;
      for (int i = 0; i < 2; i++) bb[i] = mActive[i] && (now - 1 < mEnd[i]);
      if (rst) begin
         mActive[0] = 0;
         mActive[1] = 0;
         mPrev = '0;
         mDone = '0;
         mStat = 0;
         mStatS = 0;
      end else begin
         if (|bb) begin
            if (mStat < 65535) mStat++;
            if (mStatS < 15) mStatS++;
         end
         for (int i = 0; i < 2; i++) begin
            rs  = delayEn[i] && !mPrev[i];
            nat = bb[i] && (mEnd[i] == now);
            if (rs && (!bb[i] || retrig[i])) begin
               nat = 0;
               len = int'(delayLen[i*13 +: 13]);
               if (len > 0) begin
                  mActive[i] = 1;
                  mEnd[i] = now + len;
               end else begin
                  mActive[i] = 0;
               end
            end
            mDone[i] = nat;
         end
         mPrev = delayEn;
      end
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      delayEn = '0;
      retrig = '0;
      delayLen = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      delayEn = 2'b11;
      delayLen = {13'd3, 13'd3};
      tick();
      delayEn = '0;
      tick();
      checks++;
      if (obs !== expVec()) begin
         $display("FAIL reset_model got %h exp %h", obs, expVec());
         errors++;
      end
      checks++;
      if ({pcEn, busy, done, stallCycles, sStall} !== {1'b1, 2'b00, 2'b00, 16'd0, 4'd0}) begin
         $display("FAIL reset_state got pcEn=%b busy=%b done=%b stall=%0d exp 1/00/00/0",
                  pcEn, busy, done, stallCycles);
         errors++;
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int lows = 0;
      int dones = 0;
      int doneCyc = -1;
      doReset();
      delayLen[12:0] = 13'd5;
      delayEn = 2'b01;
      for (int c = 1; c <= 12; c++) begin
         tick();
         delayEn = '0;
         checks++;
         if (obs !== expVec()) begin
            $display("FAIL basic_model cyc=%0d got %h exp %h", c, obs, expVec());
            errors++;
         end
         if (!pcEn) lows++;
         if (done[0]) begin
            dones++;
            doneCyc = c;
         end
      end
      checks++;
      if (lows != 5 || dones != 1 || doneCyc != 6) begin
         $display("FAIL basic_timing got lows=%0d dones=%0d doneCyc=%0d exp 5/1/6",
                  lows, dones, doneCyc);
         errors++;
      end
      checks++;
      if (stallCycles !== 16'd5) begin
         $display("FAIL basic_stat got %0d exp 5", stallCycles);
         errors++;
      end
   endtask

   task automatic test_zero();
      int seen = 0;
      logic [15:0] st0;
      doReset();
      st0 = stallCycles;
      delayLen = '0;
      delayEn = 2'b10;
      for (int c = 1; c <= 6; c++) begin
         tick();
         checks++;
         if (obs !== expVec()) begin
            $display("FAIL zero_model cyc=%0d got %h exp %h", c, obs, expVec());
            errors++;
         end
         if (busy != 0 || done != 0 || !pcEn) seen++;
      end
      delayEn = '0;
      checks++;
      if (seen != 0 || stallCycles !== st0) begin
         $display("FAIL zero_len got activity=%0d stall=%0d exp 0/%0d", seen, stallCycles, st0);
         errors++;
      end
   endtask

   task automatic test_retrig();
      for (int mode = 1; mode >= 0; mode--) begin
         int lows = 0;
         int dones = 0;
         int expLows = (mode == 1) ? 7 : 10;
         doReset();
         retrig = 2'(mode);
         delayLen[12:0] = 13'd10;
         delayEn = 2'b01;
         for (int c = 1; c <= 20; c++) begin
            tick();
            delayEn = (c == 4) ? 2'b01 : 2'b00;
            if (c == 4) delayLen[12:0] = 13'd3;
            checks++;
            if (obs !== expVec()) begin
               $display("FAIL retrig%0d_model cyc=%0d got %h exp %h", mode, c, obs, expVec());
               errors++;
            end
            if (!pcEn) lows++;
            if (done[0]) dones++;
         end
         checks++;
         if (lows != expLows || dones != 1) begin
            $display("FAIL retrig%0d_total got lows=%0d dones=%0d exp %0d/1",
                     mode, lows, dones, expLows);
            errors++;
         end
      end
      retrig = '0;
   endtask

   task automatic test_overlap();
      int d0 = -1;
      int d1 = -1;
      doReset();
      delayLen = {13'd6, 13'd4};
      delayEn = 2'b01;
      for (int c = 0; c <= 11; c++) begin
         tick();
         if (c == 1) delayEn = 2'b11;
         checks++;
         if (obs !== expVec() || pcEn !== (c > 7)) begin
            $display("FAIL overlap cyc=%0d got %h pcEn=%b exp %h pcEn=%b",
                     c, obs, pcEn, expVec(), (c > 7));
            errors++;
         end
         if (done[0]) d0 = c;
         if (done[1]) d1 = c;
      end
      checks++;
      if (d0 != 4 || d1 != 8 || stallCycles !== 16'd8) begin
         $display("FAIL overlap_done got d0=%0d d1=%0d stall=%0d exp 4/8/8", d0, d1, stallCycles);
         errors++;
      end
      delayEn = '0;
   endtask

   task automatic test_reset_mid();
      int lows = 0;
      int dones = 0;
      doReset();
      delayLen[12:0] = 13'd20;
      delayEn = 2'b01;
      for (int c = 0; c <= 6; c++) tick();
      rst = 1'b1;
      tick();
      checks++;
      if (pcEn !== 1'b1 || done !== 2'b00 || stallCycles !== 16'd0 || obs !== expVec()) begin
         $display("FAIL reset_mid got pcEn=%b done=%b stall=%0d exp 1/00/0", pcEn, done,
                  stallCycles);
         errors++;
      end
      rst = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         tick();
         checks++;
         if (obs !== expVec()) begin
            $display("FAIL reset_mid_model cyc=%0d got %h exp %h", c, obs, expVec());
            errors++;
         end
         if (!pcEn) lows++;
         if (done[0]) dones++;
      end
      checks++;
      if (lows != 20 || dones != 1) begin
         $display("FAIL reset_mid_restart got lows=%0d dones=%0d exp 20/1", lows, dones);
         errors++;
      end
      delayEn = '0;
   endtask

   task automatic test_saturation();
      doReset();
      delayLen[12:0] = 13'd20;
      delayEn = 2'b01;
      for (int c = 1; c <= 25; c++) begin
         tick();
         delayEn = '0;
      end
      checks++;
      if (sStall !== 4'd15 || stallCycles !== 16'd20 || obs !== expVec()) begin
         $display("FAIL saturation got sat=%0d full=%0d exp 15/20", sStall, stallCycles);
         errors++;
      end
   endtask

   task automatic test_maxlen();
      int lows = 0;
      doReset();
      delayLen = {13'd0, 13'h1fff};
      delayEn = 2'b01;
      for (int c = 1; c <= 8195; c++) begin
         tick();
         delayEn = '0;
         if (!pcEn) lows++;
         if (c % 1024 == 0 || c == 8192) begin
            checks++;
            if (obs !== expVec()) begin
               $display("FAIL maxlen_model cyc=%0d got %h exp %h", c, obs, expVec());
               errors++;
            end
         end
      end
      checks++;
      if (lows != 8191 || stallCycles !== 16'd8191) begin
         $display("FAIL maxlen got lows=%0d stall=%0d exp 8191/8191", lows, stallCycles);
         errors++;
      end
   endtask

   task automatic test_random();
      doReset();
      for (int c = 1; c <= 600; c++) begin
         for (int i = 0; i < 2; i++) begin
            if ($urandom_range(0, 2) == 0) delayEn[i] = ~delayEn[i];
            delayLen[i*13 +: 13] = 13'($urandom_range(0, 12));
            retrig[i] = 1'($urandom_range(0, 1));
         end
         rst = ($urandom_range(0, 99) == 0);
         tick();
         checks++;
         if (obs !== expVec()) begin
            $display("FAIL random cyc=%0d got %h exp %h", c, obs, expVec());
            errors++;
         end
      end
      rst = 1'b0;
      delayEn = '0;
   endtask

   initial begin
      rst = 1'b1;
      delayEn = '0;
      delayLen = '0;
      retrig = '0;
      test_reset();
      test_basic();
      test_zero();
      test_retrig();
      test_overlap();
      test_reset_mid();
      test_saturation();
      test_maxlen();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
